// File: rtl/pulse_gen.sv
// Programmable burst pulse generator: N pulses of high_len/low_len cycles per start command.
// Optional PULSE_GEN_LOOP_EN: nr_pulses==0 runs continuously until stop or reset.
module pulse_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NR_W-1:0]  nr_pulses,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [NR_W-1:0]  pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [NR_W-1:0]  nr_q, nr_d;
  logic [NR_W-1:0]  pulse_cnt_d;
  logic             out_d, busy_d, done_d;

  logic [CNT_W-1:0] high_reload;
  logic [CNT_W-1:0] low_reload;
  logic [NR_W-1:0]  cnt_inc;
  logic             start_burst;
  logic             last_pulse;

  // Phase counters hold length-1 so a zero length behaves as one cycle
  assign high_reload = (high_len == '0) ? CNT_W'(0) : CNT_W'(high_len - CNT_W'(1));
  assign low_reload  = (low_len == '0)  ? CNT_W'(0) : CNT_W'(low_len - CNT_W'(1));
  assign cnt_inc     = (&pulse_cnt) ? pulse_cnt : NR_W'(pulse_cnt + NR_W'(1));

`ifdef PULSE_GEN_LOOP_EN
  assign start_burst = start && !stop;
  assign last_pulse  = (nr_q != '0) && (cnt_inc == nr_q);
`else
  assign start_burst = start && !stop && (nr_pulses != '0);
  assign last_pulse  = (cnt_inc == nr_q);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    high_d      = high_q;
    low_d       = low_q;
    nr_d        = nr_q;
    pulse_cnt_d = pulse_cnt;
    out_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_burst) begin
          state_d     = HIGH;
          high_d      = high_reload;
          low_d       = low_reload;
          nr_d        = nr_pulses;
          phase_d     = high_reload;
          pulse_cnt_d = '0;
          out_d       = 1'b1;
          busy_d      = 1'b1;
        end else if (start && !stop) begin
          // Empty burst completes immediately
          pulse_cnt_d = '0;
          done_d      = 1'b1;
        end
      end
      HIGH: begin
        out_d  = 1'b1;
        busy_d = 1'b1;
        if (stop) begin
          state_d = IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (phase_q == '0) begin
          pulse_cnt_d = cnt_inc;
          out_d       = 1'b0;
          if (last_pulse) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            phase_d = low_q;
          end
        end else begin
          phase_d = CNT_W'(phase_q - CNT_W'(1));
        end
      end
      LOW: begin
        busy_d = 1'b1;
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (phase_q == '0) begin
          state_d = HIGH;
          phase_d = high_q;
          out_d   = 1'b1;
        end else begin
          phase_d = CNT_W'(phase_q - CNT_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      high_q    <= '0;
      low_q     <= '0;
      nr_q      <= '0;
      pulse_cnt <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      high_q    <= high_d;
      low_q     <= low_d;
      nr_q      <= nr_d;
      pulse_cnt <= pulse_cnt_d;
      out       <= out_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Programmable edge/pulse stimulus generator; produces level waveforms with controlled rising/falling edges.
- Acts as the source end of the edge-detection path: its `out` drives the `in` port of `front` in bench and demo top levels.
- On a start command it emits a burst of N pulses with configurable high/low durations, then signals completion.

Parameters:
- CNT_W, 8, width of high_len / low_len phase counters
- NR_W, 8, width of nr_pulses and pulse_cnt

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  1-cycle command; begins a burst when idle
- stop  input  1  abort current burst
- high_len  input  CNT_W  clock cycles out stays 1 per pulse (0 treated as 1)
- low_len  input  CNT_W  clock cycles out stays 0 between pulses (0 treated as 1)
- nr_pulses  input  NR_W  pulses per burst
- out  output  1  generated waveform, registered
- busy  output  1  burst in progress
- done  output  1  1-cycle pulse at normal burst completion
- pulse_cnt  output  NR_W  pulses completed in current/last burst

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n low (asynchronous) forces state IDLE, out=0, busy=0, done=0, pulse_cnt=0, and all internal counters to 0.
  - Reset mid-burst aborts immediately; no done pulse is generated.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - start=1 and stop=0 and nr_pulses!=0: latch high_len, low_len, nr_pulses; clear pulse_cnt; go to HIGH.
  - Latency: start sampled at edge k, so out=1 and busy=1 from edge k+1.
  - start with nr_pulses==0: stay IDLE; done=1 for one cycle at edge k+1; out stays 0; pulse_cnt cleared.
- HIGH:
  - out=1 for exactly max(high_len,1) cycles.
  - At phase end, pulse_cnt increments.
  - If pulse_cnt+1 == latched nr_pulses: go to IDLE, out=0, busy=0, done=1 in the same cycle out falls.
  - Otherwise go to LOW.
- LOW:
  - out=0 for exactly max(low_len,1) cycles, then back to HIGH.
- Burst timing:
  - No trailing low phase after the last pulse.
  - Total burst length is N*H + (N-1)*L cycles.
- Configuration latching: inputs are latched at start; changes during busy have no effect.
- Simultaneous and boundary events:
  - start while busy is ignored.
  - stop while busy: next edge gives IDLE, out=0, busy=0, done=0; pulse_cnt holds its value (pulses completed so far).
  - stop and start in the same cycle in IDLE: stop wins, nothing happens.
  - stop in IDLE: no effect.
  - On the final cycle of the last HIGH phase, stop and natural completion coincide: stop wins, done=0, and pulse_cnt does not increment.
- Counter rules:
  - Phase counter is CNT_W bits, counts down from the latched length minus 1 to 0.
  - pulse_cnt saturates at all-ones and does not wrap (only reachable in loop mode).
- Output registering: all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PULSE_GEN_LOOP_EN
- Defined:
  - nr_pulses==0 at start means continuous mode: HIGH/LOW alternate indefinitely until stop or reset.
  - done is never asserted in continuous mode.
  - pulse_cnt increments per pulse and saturates.
- Not defined: nr_pulses==0 gives the immediate done behaviour described under Behaviour; no loop logic is synthesized.

Test Plan:
- Reset then idle: rst_n released, no start for 10 cycles -> out=0, busy=0, done=0, pulse_cnt=0 throughout.
- Basic burst: high_len=2, low_len=3, nr_pulses=3, start at edge k ->
  - out=1 at edges k+1..k+2, 0 at k+3..k+5, 1 at k+6..k+7, 0 at k+8..k+10, 1 at k+11..k+12, 0 at k+13.
  - done=1 only at k+13; pulse_cnt=3.
  - Connected front reports 3 pos_edge and 3 neg_edge pulses.
- Zero-length/zero-count: high_len=0, low_len=0, nr_pulses=2 -> out toggles 1,0,1 then 0, one cycle each, done at edge k+4. nr_pulses=0 (macro off) -> done at k+1, out never 1.
- Abort: high_len=4, low_len=4, nr_pulses=5, stop asserted 10 cycles after start -> out=0 and busy=0 next edge, done never asserted, pulse_cnt=1.
- Collisions: start during busy -> ignored, burst length unchanged. start+stop together in IDLE -> no activity. rst_n low mid-HIGH -> out=0 asynchronously, all outputs at reset values.
- Loop mode (PULSE_GEN_LOOP_EN): high_len=1, low_len=1, nr_pulses=0 -> square wave of period 2 for 20 cycles, done=0, pulse_cnt=10 at stop; stop gives out=0 next edge.
